// File: rtl/addsub_pipe.sv
// Two-stage signed add/sub/accumulate pipe; result 2 cycles after accept, optional saturation.
// Backpressure: out_valid & ~out_ready freezes both stages and drops in_ready combinationally.
module addsub_pipe #(
   parameter int WIDTH = 36,
   parameter bit SAT   = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] x,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [1:0]       s1_op;
   logic [WIDTH-1:0] acc;

   logic             stall;
   logic [WIDTH-1:0] base;
   logic [WIDTH-1:0] operand;
   logic [WIDTH:0]   exact;
   logic [WIDTH-1:0] result;
   logic             res_ovf;

   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   // A clear coinciding with an accumulate op hands that op a zero base.
   always_comb begin
      base    = s1_op[1] ? (acc_clr ? '0 : acc) : s1_a;
      operand = s1_op[1] ? s1_a : s1_b;
      if (s1_op[0])
         exact = {base[WIDTH-1], base} - {operand[WIDTH-1], operand};
      else
         exact = {base[WIDTH-1], base} + {operand[WIDTH-1], operand};
      res_ovf = exact[WIDTH] ^ exact[WIDTH-1];
      result  = exact[WIDTH-1:0];
      if (SAT && res_ovf)
         result = exact[WIDTH] ? MIN_NEG : MAX_POS;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid  <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_op     <= '0;
         out_valid <= 1'b0;
         x         <= '0;
         ovf       <= 1'b0;
         acc       <= '0;
      end else begin
         if (!stall) begin
            s1_valid  <= in_valid;
            if (in_valid) begin
               s1_a  <= a;
               s1_b  <= b;
               s1_op <= op;
            end
            out_valid <= s1_valid;
            if (s1_valid) begin
               x   <= result;
               ovf <= res_ovf;
            end
         end
         if (!stall && s1_valid && s1_op[1])
            acc <= result;
         else if (acc_clr)
            acc <= '0;
      end
   end

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: wrap and saturating instances share stimulus and are
// checked against an integer-arithmetic model and an in-order scoreboard.
module tb_addsub_pipe;

   localparam int W = 36;
   localparam longint MAXV = (longint'(1) << (W-1)) - 1;
   localparam longint MINV = -(longint'(1) << (W-1));

   typedef struct {
      logic [W-1:0] x0;
      logic         o0;
      logic [W-1:0] x1;
      logic         o1;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         in_valid;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [1:0]   op;
   logic         acc_clr;
   logic         out_ready;
   logic         in_ready0, out_valid0, ovf0;
   logic         in_ready1, out_valid1, ovf1;
   logic [W-1:0] x0, x1;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] macc0, macc1;
   exp_t         q[$];

   addsub_pipe #(.WIDTH(W), .SAT(1'b0)) dut0 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
      .a(a), .b(b), .op(op), .acc_clr(acc_clr), .out_valid(out_valid0),
      .out_ready(out_ready), .x(x0), .ovf(ovf0));

   addsub_pipe #(.WIDTH(W), .SAT(1'b1)) dut1 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
      .a(a), .b(b), .op(op), .acc_clr(acc_clr), .out_valid(out_valid1),
      .out_ready(out_ready), .x(x1), .ovf(ovf1));

   always #5 clk = ~clk;

   // Exact signed arithmetic in 64 bits, then wrap or clamp to W bits.
   function automatic void calc(input logic [1:0] o, input logic [W-1:0] av,
                                input logic [W-1:0] bv, input bit sat,
                                input logic [W-1:0] accv,
                                output logic [W-1:0] xr, output logic of);
      longint la, lb, lacc, base, opd, ex, r;
      la   = longint'($signed(av));
      lb   = longint'($signed(bv));
      lacc = longint'($signed(accv));
      base = o[1] ? lacc : la;
      opd  = o[1] ? la : lb;
      ex   = o[0] ? base - opd : base + opd;
      of   = (ex > MAXV) || (ex < MINV);
      r    = ex;
      if (sat && of) r = (ex > 0) ? MAXV : MINV;
      xr   = r[W-1:0];
   endfunction

   function automatic exp_t predict(input logic [1:0] o, input logic [W-1:0] av,
                                    input logic [W-1:0] bv);
      exp_t e;
      calc(o, av, bv, 1'b0, macc0, e.x0, e.o0);
      calc(o, av, bv, 1'b1, macc1, e.x1, e.o1);
      if (o[1]) begin
         macc0 = e.x0;
         macc1 = e.x1;
      end
      return e;
   endfunction

   function automatic logic [W-1:0] rnd_val();
      logic [63:0]  t;
      logic [W-1:0] v;
      t = {$urandom, $urandom};
      case ($urandom_range(0, 7))
         0: begin v = '1; v[W-1] = 1'b0; end
         1: begin v = '0; v[W-1] = 1'b1; end
         2: v = W'($urandom_range(0, 20)) - W'(10);
         default: v = t[W-1:0];
      endcase
      return v;
   endfunction

   task automatic idle_inputs;
      in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
      op = 2'b00; a = '0; b = '0;
   endtask

   task automatic test_reset;
      reset_n = 1'b1;
      idle_inputs();
      #1 reset_n = 1'b0;
      #2;
      total++;
      if (out_valid0 !== 1'b0 || x0 !== '0 || ovf0 !== 1'b0 || out_valid1 !== 1'b0 || x1 !== '0) begin
         bad++;
         $display("FAIL reset_async out_valid=%b x=%h ovf=%b want 0/0/0", out_valid0, x0, ovf0);
      end
      total++;
      if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_ready got=%b/%b want 1", in_ready0, in_ready1);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk); #1;
      total++;
      if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || x0 !== '0) begin
         bad++;
         $display("FAIL reset_release out_valid=%b in_ready=%b x=%h want 0/1/0", out_valid0, in_ready0, x0);
      end
   endtask

   task automatic test_basic;
      @(negedge clk);
      in_valid = 1'b1; op = 2'b00; a = W'(5); b = W'(7);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      total++;
      if (out_valid0 !== 1'b0) begin
         bad++;
         $display("FAIL basic_latency1 out_valid=%b want 0", out_valid0);
      end
      @(negedge clk); #1;
      total++;
      if (out_valid0 !== 1'b1 || x0 !== W'(12) || ovf0 !== 1'b0 || x1 !== W'(12)) begin
         bad++;
         $display("FAIL basic_add out_valid=%b x=%h ovf=%b want 1/%h/0", out_valid0, x0, ovf0, W'(12));
      end
   endtask

   task automatic test_ovf;
      logic [W-1:0] mn, mx;
      mn = '0; mn[W-1] = 1'b1;
      mx = '1; mx[W-1] = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; op = 2'b01; a = mn; b = W'(1);
      @(negedge clk);
      op = 2'b00; a = mx; b = W'(1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      total++;
      if (x0 !== mx || ovf0 !== 1'b1 || x1 !== mn || ovf1 !== 1'b1) begin
         bad++;
         $display("FAIL ovf_neg wrap=%h/%b sat=%h/%b want %h/1 %h/1", x0, ovf0, x1, ovf1, mx, mn);
      end
      @(negedge clk); #1;
      total++;
      if (x0 !== mn || ovf0 !== 1'b1 || x1 !== mx || ovf1 !== 1'b1) begin
         bad++;
         $display("FAIL ovf_pos wrap=%h/%b sat=%h/%b want %h/1 %h/1", x0, ovf0, x1, ovf1, mn, mx);
      end
   endtask

   task automatic test_accum;
      logic [1:0]   ops[4];
      logic [W-1:0] av[4];
      logic [W-1:0] ex[4];
      ops = '{2'b10, 2'b10, 2'b10, 2'b11};
      av  = '{W'(3), W'(4), W'(5), W'(2)};
      ex  = '{W'(3), W'(7), W'(12), W'(10)};
      @(negedge clk);
      acc_clr = 1'b1;
      @(negedge clk);
      acc_clr = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         if (i < 4) begin
            in_valid = 1'b1; op = ops[i]; a = av[i]; b = '1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (i >= 2) begin
            total++;
            if (out_valid0 !== 1'b1 || x0 !== ex[i-2] || x1 !== ex[i-2]) begin
               bad++;
               $display("FAIL accum_chain[%0d] out_valid=%b x=%h want 1/%h", i-2, out_valid0, x0, ex[i-2]);
            end
         end
      end
   endtask

   task automatic test_clr_coincident;
      @(negedge clk);
      acc_clr = 1'b1;
      @(negedge clk);
      acc_clr = 1'b0; in_valid = 1'b1; op = 2'b10; a = W'(100);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk); #1;
      total++;
      if (x0 !== W'(100)) begin
         bad++;
         $display("FAIL clr_setup x=%h want %h", x0, W'(100));
      end
      in_valid = 1'b1; op = 2'b10; a = W'(9);
      @(negedge clk);
      in_valid = 1'b0; acc_clr = 1'b1;
      @(negedge clk);
      acc_clr = 1'b0;
      #1;
      total++;
      if (out_valid0 !== 1'b1 || x0 !== W'(9) || x1 !== W'(9)) begin
         bad++;
         $display("FAIL clr_coincident x=%h want %h", x0, W'(9));
      end
      in_valid = 1'b1; op = 2'b10; a = '0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk); #1;
      total++;
      if (x0 !== W'(9)) begin
         bad++;
         $display("FAIL clr_acc_after x=%h want %h", x0, W'(9));
      end
   endtask

   task automatic test_backpressure;
      int sent = 0, got = 0, stalls = 0, low_rdy = 0;
      logic [W-1:0] exp_x[$];
      logic [W-1:0] prev_x;
      logic [W-1:0] e;
      bit prev_stall = 0;
      for (int c = 0; c < 40 && got < 4; c++) begin
         @(negedge clk);
         out_ready = !(out_valid0 && stalls < 3);
         if (!out_ready) stalls++;
         in_valid = (sent < 4);
         op = 2'b00; a = W'(10 + sent); b = W'(sent);
         #1;
         total++;
         if (in_ready0 !== out_ready || in_ready1 !== out_ready) begin
            bad++;
            $display("FAIL bp_in_ready got=%b want %b", in_ready0, out_ready);
         end
         if (!in_ready0) low_rdy++;
         if (prev_stall) begin
            total++;
            if (x0 !== prev_x || out_valid0 !== 1'b1) begin
               bad++;
               $display("FAIL bp_hold x=%h want %h", x0, prev_x);
            end
         end
         prev_stall = !out_ready && out_valid0;
         prev_x = x0;
         if (in_valid && in_ready0) begin
            exp_x.push_back(W'(10 + 2 * sent));
            sent++;
         end
         if (out_valid0 && out_ready) begin
            e = exp_x.pop_front();
            got++;
            total++;
            if (x0 !== e) begin
               bad++;
               $display("FAIL bp_order beat%0d x=%h want %h", got, x0, e);
            end
         end
      end
      total++;
      if (got != 4 || stalls != 3 || low_rdy != 3) begin
         bad++;
         $display("FAIL bp_counts got=%0d stalls=%0d low_rdy=%0d want 4/3/3", got, stalls, low_rdy);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      total++;
      if (out_valid0 !== 1'b0) begin
         bad++;
         $display("FAIL bp_duplicate out_valid=%b want 0", out_valid0);
      end
   endtask

   task automatic test_random;
      exp_t e;
      @(negedge clk);
      idle_inputs();
      acc_clr = 1'b1;
      @(negedge clk);
      acc_clr = 1'b0;
      macc0 = '0; macc1 = '0;
      q.delete();
      for (int c = 0; c < 420; c++) begin
         if (c < 400) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            op        = 2'($urandom_range(0, 3));
            a         = rnd_val();
            b         = rnd_val();
            out_ready = ($urandom_range(0, 3) != 0);
         end else begin
            in_valid = 1'b0; out_ready = 1'b1;
         end
         #1;
         total++;
         if (in_ready0 !== ~(out_valid0 & ~out_ready) || out_valid1 !== out_valid0) begin
            bad++;
            $display("FAIL rnd_flow in_ready=%b out_valid=%b/%b", in_ready0, out_valid0, out_valid1);
         end
         if (in_valid && in_ready0) q.push_back(predict(op, a, b));
         if (out_valid0 && out_ready) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL rnd_extra unexpected beat x=%h", x0);
            end else begin
               e = q.pop_front();
               if (x0 !== e.x0 || ovf0 !== e.o0 || x1 !== e.x1 || ovf1 !== e.o1) begin
                  bad++;
                  $display("FAIL rnd_result wrap=%h/%b sat=%h/%b want %h/%b %h/%b",
                           x0, ovf0, x1, ovf1, e.x0, e.o0, e.x1, e.o1);
               end
            end
         end
         @(negedge clk);
      end
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL rnd_drain left=%0d want 0", q.size());
      end
   endtask

   task automatic test_reset_midflight;
      int seen = 0;
      idle_inputs();
      in_valid = 1'b1; op = 2'b00; a = W'(1); b = W'(1);
      @(negedge clk);
      a = W'(2);
      @(negedge clk);
      in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      total++;
      if (out_valid0 !== 1'b0 || x0 !== '0 || ovf0 !== 1'b0 || in_ready0 !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid out_valid=%b x=%h ovf=%b in_ready=%b want 0/0/0/1",
                  out_valid0, x0, ovf0, in_ready0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #1;
         if (out_valid0 !== 1'b0) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL rst_ghost stale beats=%0d want 0", seen);
      end
      in_valid = 1'b1; op = 2'b10; a = W'(6);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk); #1;
      total++;
      if (out_valid0 !== 1'b1 || x0 !== W'(6) || x1 !== W'(6)) begin
         bad++;
         $display("FAIL rst_fresh_acc out_valid=%b x=%h want 1/%h", out_valid0, x0, W'(6));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ovf();
      test_accum();
      test_clr_coincident();
      test_backpressure();
      test_random();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
